// File: rtl/hyperram_burst_tester.sv
// hyperram_burst_tester: self-checking write/read-back traffic generator
// for the HyperRAM controller user port.
//
// Optional feature macro: HRAM_TESTER_CR0_INIT_EN (write CR0 before the pass).
//
// Ports:
//   sys_clk, reset_in (sync, active-high), start, mmcm_locked
//   controller side: cs, rd_sel, wr_sel, mem_sel, reg_sel, num_words,
//     latency, addr_in, wr_data_in, wr_data_next, rd_data_out, rd_data_valid
//   status: busy, done, pass, err_count, first_err_addr, timeout
module hyperram_burst_tester #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_BURSTS  = 16,
  parameter int                BURST_WORDS = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter logic [ADDR_W-1:0] ADDR_STRIDE = ADDR_W'(32'h10),
  parameter logic [2:0]        LATENCY     = 3'd4,
  parameter logic [31:0]       PATTERN_XOR = 32'hA5C3_1337,
  parameter int                TIMEOUT     = 1024
) (
  input  logic              sys_clk,
  input  logic              reset_in,
  input  logic              start,
  input  logic              mmcm_locked,
  output logic              cs,
  output logic              rd_sel,
  output logic              wr_sel,
  output logic              mem_sel,
  output logic              reg_sel,
  output logic [7:0]        num_words,
  output logic [2:0]        latency,
  output logic [ADDR_W-1:0] addr_in,
  output logic [DATA_W-1:0] wr_data_in,
  input  logic              wr_data_next,
  input  logic [DATA_W-1:0] rd_data_out,
  input  logic              rd_data_valid,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              timeout
);

  localparam int BW = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [7:0]    WORDS  = 8'(BURST_WORDS);
  localparam logic [BW-1:0] LAST_B = BW'(NUM_BURSTS - 1);
  localparam logic [TW-1:0] LAST_T = TW'(TIMEOUT - 1);

`ifdef HRAM_TESTER_CR0_INIT_EN
  localparam logic [ADDR_W-1:0] CR0_ADDR = ADDR_W'(32'h0000_0800);
  localparam logic [15:0] CR0_BASE  = 16'h8F1F;
  localparam logic [15:0] CR0_VALUE =
    {CR0_BASE[15:8], 1'b0, LATENCY, CR0_BASE[3:0]};
`endif

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOCK,
    S_CFG_ISSUE,
    S_CFG_DATA,
    S_WR_ISSUE,
    S_WR_DATA,
    S_GAP,
    S_RD_ISSUE,
    S_RD_DATA,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [BW-1:0]     burst_q;
  logic [7:0]        word_q;
  logic [TW-1:0]     timer_q;
  logic              rd_phase_q;
  logic [15:0]       err_q;
  logic [ADDR_W-1:0] ferr_q;
  logic              ferr_set_q;
  logic              pass_q;
  logic              tmo_q;

  logic              abort;
  logic              issue;
  logic              in_data;
  logic              word_last;
  logic              burst_last;
  logic              tmo_hit;
  logic              rd_hit;
  logic              mismatch;
  logic [DATA_W-1:0] pattern;

  assign word_last  = (word_q == WORDS - 8'd1);
  assign burst_last = (burst_q == LAST_B);
  assign tmo_hit    = (timer_q == LAST_T);
  assign in_data    = state_q inside {S_CFG_DATA, S_WR_DATA, S_RD_DATA};
  assign pattern    = DATA_W'(addr_q + ADDR_W'(word_q))
                    ^ DATA_W'(PATTERN_XOR);
  assign rd_hit     = rd_data_valid && (state_q == S_RD_DATA);

  // Read data arriving when no read burst expects it is an error too.
  always_comb begin
    mismatch = 1'b0;
    if (rd_hit)
      mismatch = (rd_data_out != pattern);
    else if (rd_data_valid)
      mismatch = !(state_q inside {S_IDLE, S_DONE});
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_LOCK;
      S_LOCK:
        if (mmcm_locked)
`ifdef HRAM_TESTER_CR0_INIT_EN
          state_d = S_CFG_ISSUE;
`else
          state_d = S_WR_ISSUE;
`endif
      S_DONE: state_d = S_IDLE;
      default: begin
        if (!mmcm_locked) begin
          abort = 1'b1;
        end else begin
          unique case (state_q)
`ifdef HRAM_TESTER_CR0_INIT_EN
            S_CFG_ISSUE: state_d = S_CFG_DATA;
            S_CFG_DATA:
              if (wr_data_next) state_d = S_GAP;
              else if (tmo_hit) abort = 1'b1;
`endif
            S_WR_ISSUE: state_d = S_WR_DATA;
            S_WR_DATA:
              if (wr_data_next && word_last) state_d = S_GAP;
              else if (tmo_hit) abort = 1'b1;
            S_GAP:
              state_d = rd_phase_q ? S_RD_ISSUE : S_WR_ISSUE;
            S_RD_ISSUE: state_d = S_RD_DATA;
            S_RD_DATA:
              if (rd_data_valid && word_last)
                state_d = burst_last ? S_DONE : S_GAP;
              else if (tmo_hit) abort = 1'b1;
            default: state_d = S_IDLE;
          endcase
        end
        if (abort) state_d = S_DONE;
      end
    endcase
  end

  always_comb begin
    issue      = 1'b0;
    wr_sel     = 1'b0;
    rd_sel     = 1'b0;
    mem_sel    = 1'b1;
    reg_sel    = 1'b0;
    num_words  = WORDS;
    addr_in    = addr_q;
    wr_data_in = '0;
    unique case (state_q)
`ifdef HRAM_TESTER_CR0_INIT_EN
      S_CFG_ISSUE, S_CFG_DATA: begin
        issue      = (state_q == S_CFG_ISSUE);
        wr_sel     = 1'b1;
        mem_sel    = 1'b0;
        reg_sel    = 1'b1;
        num_words  = 8'd1;
        addr_in    = CR0_ADDR;
        wr_data_in = DATA_W'({16'h0, CR0_VALUE});
      end
`endif
      S_WR_ISSUE, S_WR_DATA: begin
        issue      = (state_q == S_WR_ISSUE);
        wr_sel     = 1'b1;
        wr_data_in = pattern;
      end
      S_RD_ISSUE, S_RD_DATA: begin
        issue  = (state_q == S_RD_ISSUE);
        rd_sel = 1'b1;
      end
      default: ;
    endcase
  end

  // The strobe must never escape in a cycle where reset is applied.
  assign cs             = issue & ~reset_in;
  assign latency        = LATENCY;
  assign busy           = (state_q != S_IDLE);
  assign done           = (state_q == S_DONE);
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_q;
  assign timeout        = tmo_q;

  always_ff @(posedge sys_clk) begin
    if (reset_in) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      burst_q    <= '0;
      word_q     <= '0;
      timer_q    <= '0;
      rd_phase_q <= 1'b0;
      err_q      <= '0;
      ferr_q     <= '0;
      ferr_set_q <= 1'b0;
      pass_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= in_data ? timer_q + TW'(1) : '0;

      if (state_q == S_IDLE && start) begin
        addr_q     <= BASE_ADDR;
        burst_q    <= '0;
        word_q     <= '0;
        rd_phase_q <= 1'b0;
        err_q      <= '0;
        ferr_q     <= '0;
        ferr_set_q <= 1'b0;
        pass_q     <= 1'b0;
        tmo_q      <= 1'b0;
      end

      if ((wr_data_next && state_q == S_WR_DATA) || rd_hit)
        word_q <= word_last ? 8'd0 : word_q + 8'd1;

      if (state_q == S_WR_DATA && state_d == S_GAP) begin
        if (burst_last) begin
          burst_q    <= '0;
          addr_q     <= BASE_ADDR;
          rd_phase_q <= 1'b1;
        end else begin
          burst_q <= burst_q + BW'(1);
          addr_q  <= addr_q + ADDR_STRIDE;
        end
      end

      if (state_q == S_RD_DATA && state_d == S_GAP) begin
        burst_q <= burst_q + BW'(1);
        addr_q  <= addr_q + ADDR_STRIDE;
      end

      if (mismatch && err_q != 16'hFFFF)
        err_q <= err_q + 16'd1;

      if (rd_hit && mismatch && !ferr_set_q) begin
        ferr_q     <= addr_q + ADDR_W'(word_q);
        ferr_set_q <= 1'b1;
      end

      if (abort) tmo_q <= 1'b1;

      // Include this cycle's compare so pass is valid in the done cycle.
      if (state_d == S_DONE && state_q != S_DONE)
        pass_q <= !abort && (err_q == 16'd0) && !mismatch;
    end
  end

endmodule

// File: tb/tb_hyperram_burst_tester.sv
// tb_hyperram_burst_tester: randomized controller responder plus
// reference pattern model for hyperram_burst_tester.
module tb_hyperram_burst_tester;

  localparam int          NB     = 16;
  localparam int          BWD    = 4;
  localparam int          TMO    = 1024;
  localparam logic [31:0] BASE   = 32'h0;
  localparam logic [31:0] STRIDE = 32'h10;
  localparam logic [31:0] XOR    = 32'hA5C3_1337;

  logic        sys_clk = 1'b0;
  logic        reset_in = 1'b1;
  logic        start = 1'b0;
  logic        mmcm_locked = 1'b0;
  logic        cs, rd_sel, wr_sel, mem_sel, reg_sel;
  logic [7:0]  num_words;
  logic [2:0]  latency;
  logic [31:0] addr_in, wr_data_in;
  logic        wr_data_next = 1'b0;
  logic [31:0] rd_data_out = '0;
  logic        rd_data_valid = 1'b0;
  logic        busy, done, pass, timeout;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;

  hyperram_burst_tester #(
    .ADDR_W(32), .DATA_W(32), .NUM_BURSTS(NB), .BURST_WORDS(BWD),
    .BASE_ADDR(BASE), .ADDR_STRIDE(STRIDE), .LATENCY(3'd4),
    .PATTERN_XOR(XOR), .TIMEOUT(TMO)
  ) dut (
    .sys_clk(sys_clk), .reset_in(reset_in), .start(start),
    .mmcm_locked(mmcm_locked), .cs(cs), .rd_sel(rd_sel),
    .wr_sel(wr_sel), .mem_sel(mem_sel), .reg_sel(reg_sel),
    .num_words(num_words), .latency(latency), .addr_in(addr_in),
    .wr_data_in(wr_data_in), .wr_data_next(wr_data_next),
    .rd_data_out(rd_data_out), .rd_data_valid(rd_data_valid),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .timeout(timeout)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;

  // Responder knobs, written only by the test tasks.
  bit          no_valid = 0;
  bit          corrupt_en = 0;
  logic [31:0] corrupt_addr = '0;
  bit          stray_req = 0;

  // Responder state, written only by the responder.
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_addrs [$];
  bit          m_wr = 0, m_rd = 0, m_reg = 0, extra_pend = 0, prev_cs = 0;
  logic [31:0] m_addr = '0, ra = '0, rd = '0;
  logic [7:0]  m_nw = '0;
  int          m_k = 0, m_end_cyc = -100;
  int          wr_cs = 0, rd_cs = 0, reg_cs = 0, proto_bad = 0;
  int          rd_cs_cyc = 0;
  logic [31:0] cr0_addr = '0, cr0_data = '0;

  function automatic logic [31:0] exp_word(input logic [31:0] a,
                                           input int k);
    return (a + 32'(k)) ^ XOR;
  endfunction

  // Behaves like the controller: random wr_data_next / rd_data_valid
  // spacing, memory backing store, and protocol monitoring.
  always @(negedge sys_clk) begin
    wr_data_next  = 1'b0;
    rd_data_valid = 1'b0;
    if (!busy) begin
      m_wr = 0; m_rd = 0; extra_pend = 0;
    end else if ((m_wr || m_rd) && !done) begin
      if (addr_in !== m_addr || wr_sel !== m_wr || rd_sel !== m_rd ||
          num_words !== m_nw)
        proto_bad++;
    end
    if (cs === 1'b1) begin
      if (prev_cs || reset_in || wr_sel === rd_sel ||
          cyc - m_end_cyc < 2)
        proto_bad++;
      m_addr = addr_in; m_nw = num_words; m_k = 0;
      m_wr = wr_sel; m_rd = rd_sel; m_reg = reg_sel;
      if (rd_sel) begin
        rd_cs++; rd_cs_cyc = cyc;
      end else if (reg_sel) begin
        reg_cs++; cr0_addr = addr_in;
      end else begin
        wr_cs++; wr_addrs.push_back(addr_in);
      end
    end else if (extra_pend) begin
      wr_data_next = 1'b1;
      extra_pend = 0;
    end else if (m_wr && $urandom_range(0, 2) != 0) begin
      wr_data_next = 1'b1;
      if (m_reg) cr0_data = wr_data_in;
      else mem[m_addr + 32'(m_k)] = wr_data_in;
      m_k++;
      if (m_k == int'(m_nw)) begin
        m_wr = 0; m_end_cyc = cyc;
        extra_pend = ($urandom_range(0, 3) == 0);
      end
    end else if (m_rd && !no_valid && $urandom_range(0, 2) != 0) begin
      ra = m_addr + 32'(m_k);
      rd = mem.exists(ra) ? mem[ra] : 32'h0;
      if (corrupt_en && ra == corrupt_addr) rd[0] = ~rd[0];
      rd_data_valid = 1'b1;
      rd_data_out = rd;
      m_k++;
      if (m_k == int'(m_nw)) begin
        m_rd = 0; m_end_cyc = cyc;
      end
    end
    if (stray_req && !rd_data_valid) begin
      rd_data_valid = 1'b1;
      rd_data_out = $urandom;
    end
    prev_cs = cs;
  end

  task automatic do_start();
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge sys_clk);
      if (done === 1'b1) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    reset_in = 1'b1; start = 1'b1; mmcm_locked = 1'b1;
    repeat (3) @(negedge sys_clk);
    reset_in = 1'b0; start = 1'b0;
    @(negedge sys_clk);
    n_vec++; if (cs !== 1'b0) begin n_mis++; $display("FAIL rst_cs: got %0h want 0", cs); end
    n_vec++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %0h want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_mis++; $display("FAIL rst_done: got %0h want 0", done); end
    n_vec++; if (pass !== 1'b0) begin n_mis++; $display("FAIL rst_pass: got %0h want 0", pass); end
    n_vec++; if (timeout !== 1'b0) begin n_mis++; $display("FAIL rst_timeout: got %0h want 0", timeout); end
    n_vec++; if (err_count !== 16'h0) begin n_mis++; $display("FAIL rst_err: got %0h want 0", err_count); end
    n_vec++; if (first_err_addr !== 32'h0) begin n_mis++; $display("FAIL rst_ferr: got %0h want 0", first_err_addr); end
    n_vec++; if ({rd_sel, wr_sel, reg_sel} !== 3'b000) begin n_mis++; $display("FAIL rst_sel: got %0b want 000", {rd_sel, wr_sel, reg_sel}); end
    n_vec++; if (mem_sel !== 1'b1) begin n_mis++; $display("FAIL rst_mem_sel: got %0h want 1", mem_sel); end
    n_vec++; if (num_words !== 8'(BWD)) begin n_mis++; $display("FAIL rst_num_words: got %0d want %0d", num_words, BWD); end
    n_vec++; if (latency !== 3'd4) begin n_mis++; $display("FAIL rst_latency: got %0d want 4", latency); end
    n_vec++; if (addr_in !== 32'h0) begin n_mis++; $display("FAIL rst_addr: got %0h want 0", addr_in); end
    n_vec++; if (wr_data_in !== 32'h0) begin n_mis++; $display("FAIL rst_wdata: got %0h want 0", wr_data_in); end
    repeat (5) @(negedge sys_clk);
    n_vec++; if (busy !== 1'b0) begin n_mis++; $display("FAIL rst_start_ignored: busy got %0h want 0", busy); end
  endtask

  task automatic test_clean_pass();
    int w0, r0, g0, p0, a0;
    bit ok;
    logic [31:0] ba, a;
    w0 = wr_cs; r0 = rd_cs; g0 = reg_cs; p0 = proto_bad;
    a0 = wr_addrs.size();
    mmcm_locked = 1'b1;
    do_start();
    repeat (20) @(negedge sys_clk);
    start = 1'b1; @(negedge sys_clk); start = 1'b0;
    wait_done(6000, ok);
    n_vec++; if (!ok) begin n_mis++; $display("FAIL clean_done: got none want done pulse"); end
    n_vec++; if (pass !== 1'b1) begin n_mis++; $display("FAIL clean_pass: got %0h want 1", pass); end
    n_vec++; if (err_count !== 16'h0) begin n_mis++; $display("FAIL clean_err: got %0d want 0", err_count); end
    n_vec++; if (timeout !== 1'b0) begin n_mis++; $display("FAIL clean_timeout: got %0h want 0", timeout); end
    n_vec++; if (busy !== 1'b1) begin n_mis++; $display("FAIL clean_busy_in_done: got %0h want 1", busy); end
    n_vec++; if (wr_cs - w0 !== NB) begin n_mis++; $display("FAIL clean_wr_cs: got %0d want %0d", wr_cs - w0, NB); end
    n_vec++; if (rd_cs - r0 !== NB) begin n_mis++; $display("FAIL clean_rd_cs: got %0d want %0d", rd_cs - r0, NB); end
`ifdef HRAM_TESTER_CR0_INIT_EN
    n_vec++; if (reg_cs - g0 !== 1) begin n_mis++; $display("FAIL cr0_cs: got %0d want 1", reg_cs - g0); end
    n_vec++; if (cr0_addr !== 32'h800) begin n_mis++; $display("FAIL cr0_addr: got %0h want 800", cr0_addr); end
    n_vec++; if (cr0_data !== 32'h0000_8F4F) begin n_mis++; $display("FAIL cr0_data: got %0h want 8f4f", cr0_data); end
`else
    n_vec++; if (reg_cs - g0 !== 0) begin n_mis++; $display("FAIL reg_cs: got %0d want 0", reg_cs - g0); end
`endif
    for (int b = 0; b < NB; b++) begin
      ba = BASE + 32'(b) * STRIDE;
      n_vec++;
      if (a0 + b >= wr_addrs.size() || wr_addrs[a0 + b] !== ba) begin
        n_mis++; $display("FAIL wr_addr[%0d]: got %0h want %0h", b,
          (a0 + b < wr_addrs.size()) ? wr_addrs[a0 + b] : 32'hx, ba);
      end
      for (int k = 0; k < BWD; k++) begin
        a = ba + 32'(k);
        n_vec++;
        if (!mem.exists(a) || mem[a] !== exp_word(ba, k)) begin
          n_mis++; $display("FAIL wdata[%0h]: got %0h want %0h", a,
            mem.exists(a) ? mem[a] : 32'hx, exp_word(ba, k));
        end
      end
    end
    @(negedge sys_clk);
    n_vec++; if (busy !== 1'b0 || done !== 1'b0) begin n_mis++; $display("FAIL clean_after: busy/done got %0b%0b want 00", busy, done); end
    n_vec++; if (proto_bad - p0 !== 0) begin n_mis++; $display("FAIL clean_protocol: got %0d violations want 0", proto_bad - p0); end
  endtask

  task automatic test_corrupt();
    int b, w;
    bit ok;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) begin b = 5; w = 2; end
      else begin b = $urandom_range(0, NB - 1); w = $urandom_range(0, BWD - 1); end
      corrupt_addr = BASE + 32'(b) * STRIDE + 32'(w);
      corrupt_en = 1;
      do_start();
      wait_done(6000, ok);
      n_vec++; if (!ok) begin n_mis++; $display("FAIL corrupt_done: got none want done pulse"); end
      n_vec++; if (pass !== 1'b0) begin n_mis++; $display("FAIL corrupt_pass: got %0h want 0", pass); end
      n_vec++; if (err_count !== 16'd1) begin n_mis++; $display("FAIL corrupt_err: got %0d want 1", err_count); end
      n_vec++; if (first_err_addr !== corrupt_addr) begin n_mis++; $display("FAIL corrupt_ferr: got %0h want %0h", first_err_addr, corrupt_addr); end
      n_vec++; if (timeout !== 1'b0) begin n_mis++; $display("FAIL corrupt_timeout: got %0h want 0", timeout); end
      corrupt_en = 0;
      repeat (3) @(negedge sys_clk);
    end
  endtask

  task automatic test_stray_valid();
    int w0;
    bit ok;
    w0 = wr_cs;
    do_start();
    for (int i = 0; i < 2000 && wr_cs - w0 < 2; i++) @(negedge sys_clk);
    @(posedge sys_clk); stray_req = 1;
    @(posedge sys_clk); stray_req = 0;
    wait_done(6000, ok);
    n_vec++; if (!ok) begin n_mis++; $display("FAIL stray_done: got none want done pulse"); end
    n_vec++; if (err_count !== 16'd1) begin n_mis++; $display("FAIL stray_err: got %0d want 1", err_count); end
    n_vec++; if (pass !== 1'b0) begin n_mis++; $display("FAIL stray_pass: got %0h want 0", pass); end
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_timeout();
    int r0, took;
    bit ok;
    r0 = rd_cs;
    no_valid = 1;
    do_start();
    wait_done(8000, ok);
    took = cyc - rd_cs_cyc;
    n_vec++; if (!ok) begin n_mis++; $display("FAIL tmo_done: got none want done pulse"); end
    n_vec++; if (rd_cs - r0 !== 1) begin n_mis++; $display("FAIL tmo_rd_cs: got %0d want 1", rd_cs - r0); end
    n_vec++; if (took < TMO || took > TMO + 2) begin n_mis++; $display("FAIL tmo_latency: got %0d cycles want %0d..%0d", took, TMO, TMO + 2); end
    n_vec++; if (timeout !== 1'b1) begin n_mis++; $display("FAIL tmo_flag: got %0h want 1", timeout); end
    n_vec++; if (pass !== 1'b0) begin n_mis++; $display("FAIL tmo_pass: got %0h want 0", pass); end
    no_valid = 0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic test_lock_loss();
    int w0;
    w0 = wr_cs;
    do_start();
    for (int i = 0; i < 4000 && wr_cs - w0 < 4; i++) @(negedge sys_clk);
    n_vec++; if (wr_cs - w0 < 4) begin n_mis++; $display("FAIL lock_reach: got %0d bursts want 4", wr_cs - w0); end
    repeat (2) @(negedge sys_clk);
    mmcm_locked = 1'b0;
    @(negedge sys_clk);
    n_vec++; if (done !== 1'b1) begin n_mis++; $display("FAIL lock_abort_done: got %0h want 1", done); end
    n_vec++; if (timeout !== 1'b1) begin n_mis++; $display("FAIL lock_timeout: got %0h want 1", timeout); end
    n_vec++; if (pass !== 1'b0) begin n_mis++; $display("FAIL lock_pass: got %0h want 0", pass); end
    @(negedge sys_clk);
    n_vec++; if (busy !== 1'b0) begin n_mis++; $display("FAIL lock_busy: got %0h want 0", busy); end
    mmcm_locked = 1'b1;
    test_clean_pass();
  endtask

  task automatic test_reset_mid();
    int r0;
    r0 = rd_cs;
    do_start();
    for (int i = 0; i < 4000 && rd_cs - r0 < 3; i++) @(negedge sys_clk);
    repeat (2) @(negedge sys_clk);
    reset_in = 1'b1;
    @(negedge sys_clk);
    reset_in = 1'b0;
    n_vec++; if (busy !== 1'b0 || cs !== 1'b0) begin n_mis++; $display("FAIL midrst_busy_cs: got %0b%0b want 00", busy, cs); end
    n_vec++; if (err_count !== 16'h0 || pass !== 1'b0 || timeout !== 1'b0) begin n_mis++; $display("FAIL midrst_status: err %0h pass %0h tmo %0h want 0 0 0", err_count, pass, timeout); end
    n_vec++; if (addr_in !== 32'h0 || wr_data_in !== 32'h0 || mem_sel !== 1'b1) begin n_mis++; $display("FAIL midrst_port: addr %0h wdata %0h mem_sel %0h want 0 0 1", addr_in, wr_data_in, mem_sel); end
    test_clean_pass();
  endtask

  initial begin
    test_reset();
    test_clean_pass();
    test_corrupt();
    test_stray_valid();
    test_timeout();
    test_lock_loss();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
